// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial WIDTH-bit subtractor (D = A - B - Bin) with start/busy/done handshake
module serial_subtractor #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] D,
   output logic             Bout,
   output logic             V,
   output logic             Z
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t state;
   state_t next_state;

   // operand shift registers, borrow flip-flop, partial difference and bit counter
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-2:0] d_sr;
   logic             br;
   logic [CW-1:0]    cnt;

   // sign bits of the captured operands, kept for the overflow flag
   logic             a_msb;
   logic             b_msb;

   logic             accept;
   logic             last_bit;
   logic             d_bit;
   logic             br_nxt;
   logic [WIDTH-1:0] d_full;
   logic             busy_nxt;
   logic             done_nxt;

   // one-bit full subtractor on the current LSB pair
   always_comb begin
      accept   = (state == ST_IDLE) && start;
      last_bit = (state == ST_SHIFT) && (cnt == LAST_BIT);
      d_bit    = a_sr[0] ^ b_sr[0] ^ br;
      br_nxt   = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
      d_full   = {d_bit, d_sr};
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // next-state logic: start is only honoured in IDLE, DONE lasts a single cycle
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:  if (start) next_state = ST_SHIFT;
         ST_SHIFT: if (cnt == LAST_BIT) next_state = ST_DONE;
         ST_DONE:  next_state = ST_IDLE;
         default:  next_state = ST_IDLE;
      endcase
   end

   // output decode from the state being entered, so busy/done can be registered
   always_comb begin
      busy_nxt = (next_state == ST_SHIFT);
      done_nxt = (next_state == ST_DONE);
   end

   // registered handshake outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         busy <= busy_nxt;
         done <= done_nxt;
      end
   end

   // datapath: capture operands on accept, then shift one bit per cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr  <= '0;
         b_sr  <= '0;
         d_sr  <= '0;
         br    <= 1'b0;
         cnt   <= '0;
         a_msb <= 1'b0;
         b_msb <= 1'b0;
      end else if (accept) begin
         a_sr  <= A;
         b_sr  <= B;
         d_sr  <= '0;
         br    <= Bin;
         cnt   <= '0;
         a_msb <= A[WIDTH-1];
         b_msb <= B[WIDTH-1];
      end else if (state == ST_SHIFT) begin
         a_sr  <= a_sr >> 1;
         b_sr  <= b_sr >> 1;
         d_sr  <= d_full[WIDTH-1:1];
         br    <= br_nxt;
         cnt   <= cnt + 1'b1;
      end
   end

   // result registers: loaded only on the final bit so they hold across the next operation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         D    <= '0;
         Bout <= 1'b0;
         V    <= 1'b0;
         Z    <= 1'b0;
      end else if (last_bit) begin
         D    <= d_full;
         Bout <= br_nxt;
         V    <= (a_msb != b_msb) && (d_bit != a_msb);
         Z    <= (d_full == '0);
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor
module tb_serial_subtractor;

   localparam int W = 4;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] A     = '0;
   logic [W-1:0] B     = '0;
   logic         Bin   = 1'b0;
   logic         busy;
   logic         done;
   logic [W-1:0] D;
   logic         Bout;
   logic         V;
   logic         Z;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .A     (A),
      .B     (B),
      .Bin   (Bin),
      .busy  (busy),
      .done  (done),
      .D     (D),
      .Bout  (Bout),
      .V     (V),
      .Z     (Z)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] d;
      logic         bout;
      logic         v;
      logic         z;
   } res_t;

   res_t exp_q[$];
   res_t held      = '0;
   int   remaining = 0;
   int   checks    = 0;
   int   errors    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // arithmetic reference: subtract as integers, flags from the resulting word
   function automatic res_t ref_sub(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
      res_t r;
      int   diff;
      diff   = int'(a) - int'(b) - int'(bin);
      r.d    = W'(diff & ((1 << W) - 1));
      r.bout = (diff < 0);
      r.v    = (a[W-1] != b[W-1]) && (r.d[W-1] != a[W-1]);
      r.z    = (r.d == '0);
      return r;
   endfunction

   // protocol model: accept in idle, W busy cycles, one done cycle, then idle again
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         remaining = 0;
         exp_q.delete();
         held = '0;
      end else if (remaining == 0) begin
         if (start) begin
            exp_q.push_back(ref_sub(A, B, Bin));
            remaining = W + 1;
         end
      end else begin
         remaining--;
      end
   end

   // monitor: handshake timing every cycle, results on done, hold between completions
   always @(negedge clk) begin
      res_t e;
      chk("busy", busy, remaining >= 2);
      chk("done", done, remaining == 1);
      if (done) begin
         if (exp_q.size() == 0) begin
            chk("done_without_op", 1, 0);
         end else begin
            e = exp_q.pop_front();
            chk("result", {D, Bout, V, Z}, e);
            held = e;
         end
      end
      chk("hold", {D, Bout, V, Z}, held);
   end

   task automatic wait_idle();
      int n = 0;
      while (remaining != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (remaining != 0) chk("idle_timeout", 1, 0);
   endtask

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
      wait_idle();
      A     = a;
      B     = b;
      Bin   = bin;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      A     = W'($urandom);
      B     = W'($urandom);
      Bin   = 1'($urandom);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_state", {busy, done, D, Bout, V, Z}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      run_op(4'd9, 4'd3, 1'b0);
      run_op(4'd3, 4'd5, 1'b0);
      run_op(4'd7, 4'd8, 1'b0);
      run_op(4'd5, 4'd5, 1'b0);
      run_op(4'd0, 4'd0, 1'b1);
      run_op(4'd8, 4'd0, 1'b1);
      run_op(4'hF, 4'hF, 1'b1);

      repeat (25) run_op(W'($urandom), W'($urandom), 1'($urandom));

      wait_idle();
      start = 1'b1;
      repeat (40) begin
         A   = W'($urandom);
         B   = W'($urandom);
         Bin = 1'($urandom);
         @(negedge clk);
      end
      start = 1'b0;

      wait_idle();
      A     = 4'd9;
      B     = 4'd3;
      Bin   = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_outputs", {busy, done, D, Bout, V, Z}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run_op(4'd2, 4'd1, 1'b0);
      wait_idle();
      @(negedge clk);
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
